swipt_link_tx: RTL and testbench

- Transmit-side carrier generator for the SWIPT link.
- Produces the square-wave `link` signal that the receive-side PLL locks onto, at a commanded frequency in Hz.
- Also produces the `swipt_alive` and `freq_rdy` status the receiver qualifies on.
- Frequency changes are applied phase-continuously at `link` rising edges, so the receiver never sees a truncated half-period.

---
 rtl/swipt_pkg.sv | 14 +
 rtl/swipt_link_tx_if.sv | 13 +
 rtl/swipt_nco.sv | 42 ++++
 rtl/swipt_link_tx.sv | 134 +++++++++++++
 tb/tb_swipt_link_tx.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/swipt_pkg.sv
// rtl/swipt_pkg.sv - shared state type and constants for the SWIPT link transmitter
package swipt_pkg;

    localparam int FREQ_W     = 32;
    localparam int CLK_HZ_DEF = 100_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SLEW = 2'd2,
        STOP = 2'd3
    } swipt_state_e;

endpackage

// File: rtl/swipt_link_tx_if.sv
// rtl/swipt_link_tx_if.sv - frequency command handshake between host and swipt_link_tx
interface swipt_link_tx_if;
    import swipt_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [FREQ_W-1:0] cmd_freq;
    logic              cmd_err;

    modport master (output cmd_valid, output cmd_freq, input cmd_ready, input cmd_err);
    modport slave  (input cmd_valid, input cmd_freq, output cmd_ready, output cmd_err);

endinterface

// File: rtl/swipt_nco.sv
// rtl/swipt_nco.sv - phase accumulator producing the link square wave and its rising-edge pulse
module swipt_nco
    import swipt_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              run,
    input  logic [FREQ_W-1:0] cur_freq,
    output logic              link,
    output logic              link_rise
);

    localparam logic [FREQ_W-1:0] MOD = FREQ_W'(CLK_HZ);

    logic [FREQ_W-1:0] r_acc;
    logic              r_link;
    logic              r_link_rise;
    logic [FREQ_W:0]   w_sum;
    logic              w_wrap;

    // Adding 2*f per cycle makes every wrap one half-period, so link averages exactly f.
    assign w_sum  = {1'b0, r_acc} + {cur_freq, 1'b0};
    assign w_wrap = (w_sum >= {1'b0, MOD});

    always_ff @(posedge clk) begin
        if (nrst || !run) begin
            r_acc       <= '0;
            r_link      <= 1'b0;
            r_link_rise <= 1'b0;
        end else begin
            r_acc       <= w_wrap ? (w_sum[FREQ_W-1:0] - MOD) : w_sum[FREQ_W-1:0];
            r_link      <= r_link ^ w_wrap;
            r_link_rise <= w_wrap && !r_link;
        end
    end

    assign link      = r_link;
    assign link_rise = r_link_rise;

endmodule

// File: rtl/swipt_link_tx.sv
// rtl/swipt_link_tx.sv - SWIPT carrier FSM, command handshake and settle tracking; SWIPT_TX_SLEW_EN enables stepped slewing
module swipt_link_tx
    import swipt_pkg::*;
#(
    parameter int CLK_HZ         = CLK_HZ_DEF,
    parameter int F0             = 45000,
    parameter int F_MAX          = 200000,
`ifdef SWIPT_TX_SLEW_EN
    parameter int STEP_HZ        = 1000,
`endif
    parameter int SETTLE_PERIODS = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    swipt_link_tx_if.slave    cmd,
    output logic              link,
    output logic              link_rise,
    output logic              swipt_alive,
    output logic              freq_rdy,
    output logic [FREQ_W-1:0] cur_freq
);

    localparam int                SET_W      = $clog2(SETTLE_PERIODS + 1);
    localparam logic [SET_W-1:0]  SETTLE_MAX = SET_W'(SETTLE_PERIODS);
    localparam logic [FREQ_W-1:0] F0_V       = FREQ_W'(F0);
    localparam logic [FREQ_W-1:0] F_MAX_V    = FREQ_W'(F_MAX);

    swipt_state_e      r_state;
    logic [FREQ_W-1:0] r_cur_freq;
    logic [FREQ_W-1:0] r_target;
    logic [SET_W-1:0]  r_settle;
    logic              r_cmd_err;

    logic              w_ready;
    logic              w_xfer;
    logic              w_bad;
    logic              w_take;
    logic              w_retarget;
    logic              w_run;
    logic [FREQ_W-1:0] w_next_freq;

`ifdef SWIPT_TX_SLEW_EN
    localparam logic [FREQ_W-1:0] STEP_V = FREQ_W'(STEP_HZ);

    logic              w_up;
    logic [FREQ_W-1:0] w_gap;
    logic [FREQ_W-1:0] w_step;

    assign w_up        = (r_target > r_cur_freq);
    assign w_gap       = w_up ? (r_target - r_cur_freq) : (r_cur_freq - r_target);
    assign w_step      = (w_gap > STEP_V) ? STEP_V : w_gap;
    assign w_next_freq = w_up ? (r_cur_freq + w_step) : (r_cur_freq - w_step);
`else
    assign w_next_freq = r_target;
`endif

    assign w_ready    = (r_state == IDLE) || ((r_state == RUN) && (r_target == r_cur_freq));
    assign w_xfer     = cmd.cmd_valid && w_ready;
    assign w_bad      = (cmd.cmd_freq == '0) || (cmd.cmd_freq > F_MAX_V);
    assign w_take     = w_xfer && !w_bad;
    assign w_retarget = w_take && (cmd.cmd_freq != r_cur_freq);

    // In STOP the carrier only runs while finishing its high half, so no new rise can start.
    assign w_run = (r_state == RUN) || (r_state == SLEW) || ((r_state == STOP) && link);

    swipt_nco #(
        .CLK_HZ    (CLK_HZ)
    ) u_nco (
        .clk       (clk),
        .nrst      (nrst),
        .run       (w_run),
        .cur_freq  (r_cur_freq),
        .link      (link),
        .link_rise (link_rise)
    );

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state    <= IDLE;
            r_cur_freq <= F0_V;
            r_target   <= F0_V;
            r_settle   <= '0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_xfer && w_bad;
            case (r_state)
                IDLE: begin
                    r_settle <= '0;
                    if (w_take) begin
                        r_cur_freq <= cmd.cmd_freq;
                        r_target   <= cmd.cmd_freq;
                    end
                    if (en) r_state <= RUN;
                end
                RUN: begin
                    if (w_take) r_target <= cmd.cmd_freq;
                    if (!en) begin
                        r_state  <= STOP;
                        r_settle <= '0;
                    end else if (w_retarget || (r_target != r_cur_freq)) begin
                        r_state  <= SLEW;
                        r_settle <= '0;
                    end else if (link_rise && (r_settle != SETTLE_MAX)) begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                SLEW: begin
                    r_settle <= '0;
                    if (!en) begin
                        r_state <= STOP;
                    end else if (link_rise) begin
                        r_cur_freq <= w_next_freq;
                        if (w_next_freq == r_target) r_state <= RUN;
                    end else if (r_cur_freq == r_target) begin
                        r_state <= RUN;
                    end
                end
                STOP: begin
                    r_settle <= '0;
                    if (!link) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd.cmd_ready = w_ready;
    assign cmd.cmd_err   = r_cmd_err;
    assign swipt_alive   = (r_state != IDLE);
    assign freq_rdy      = (r_state == RUN) && (r_settle == SETTLE_MAX);
    assign cur_freq      = r_cur_freq;

endmodule

// File: tb/tb_swipt_link_tx.sv
// tb/tb_swipt_link_tx.sv - randomized self-checking bench for swipt_link_tx against a phase-level reference model
module tb_swipt_link_tx;

    localparam longint      CLK_HZ = 100000000;
    localparam int unsigned F0     = 45000;
    localparam int unsigned F_MAX  = 200000;
    localparam int          SETTLE = 8;
`ifdef SWIPT_TX_SLEW_EN
    localparam int unsigned STEP_HZ = 1000;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_SLEW = 2;
    localparam int M_STOP = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic        link;
    logic        link_rise;
    logic        swipt_alive;
    logic        freq_rdy;
    logic [31:0] cur_freq;

    swipt_link_tx_if cmd_if();

    swipt_link_tx dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .cmd         (cmd_if),
        .link        (link),
        .link_rise   (link_rise),
        .swipt_alive (swipt_alive),
        .freq_rdy    (freq_rdy),
        .cur_freq    (cur_freq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      cyc   = 0;

    // Reference model: carrier described by total phase, link = parity of completed half-periods.
    int          m_mode;
    int          m_settle;
    longint      m_p;
    bit          m_link;
    bit          m_rise;
    bit          m_err;
    int unsigned m_cur;
    int unsigned m_target;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_ready();
        return (m_mode == M_IDLE) || (m_mode == M_RUN && m_target == m_cur);
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({m_link, m_rise, exp_ready(), m_err, (m_mode != M_IDLE),
                    (m_mode == M_RUN && m_settle == SETTLE), m_cur});
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({link, link_rise, cmd_if.cmd_ready, cmd_if.cmd_err, swipt_alive, freq_rdy, cur_freq});
    endfunction

    task automatic model_step();
        bit          xfer;
        bit          bad;
        bit          take;
        bit          old_link;
        bit          old_rise;
        bit          running;
        longint      h_before;
        longint      h_after;
        int unsigned f;
        if (nrst) begin
            m_mode = M_IDLE; m_p = 0; m_link = 0; m_rise = 0;
            m_cur = F0; m_target = F0; m_settle = 0; m_err = 0;
            return;
        end
        f        = cmd_if.cmd_freq;
        xfer     = cmd_if.cmd_valid && exp_ready();
        bad      = (f == 0) || (f > F_MAX);
        take     = xfer && !bad;
        old_link = m_link;
        old_rise = m_rise;
        running  = (m_mode == M_RUN) || (m_mode == M_SLEW) || (m_mode == M_STOP && old_link);
        m_err    = xfer && bad;
        if (running) begin
            h_before = m_p / CLK_HZ;
            m_p      = m_p + 2 * longint'(m_cur);
            h_after  = m_p / CLK_HZ;
            m_link   = h_after[0];
            m_rise   = (h_after != h_before) && h_after[0];
        end else begin
            m_p = 0; m_link = 0; m_rise = 0;
        end
        case (m_mode)
            M_IDLE: begin
                m_settle = 0;
                if (take) begin m_cur = f; m_target = f; end
                if (en) m_mode = M_RUN;
            end
            M_RUN: begin
                if (take) m_target = f;
                if (!en) begin m_mode = M_STOP; m_settle = 0; end
                else if (m_target != m_cur) begin m_mode = M_SLEW; m_settle = 0; end
                else if (old_rise) m_settle = (m_settle < SETTLE) ? m_settle + 1 : SETTLE;
            end
            M_SLEW: begin
                m_settle = 0;
                if (!en) m_mode = M_STOP;
                else if (old_rise) begin
`ifdef SWIPT_TX_SLEW_EN
                    if (m_target > m_cur)
                        m_cur = m_cur + (((m_target - m_cur) < STEP_HZ) ? (m_target - m_cur) : STEP_HZ);
                    else
                        m_cur = m_cur - (((m_cur - m_target) < STEP_HZ) ? (m_cur - m_target) : STEP_HZ);
`else
                    m_cur = m_target;
`endif
                    if (m_cur == m_target) m_mode = M_RUN;
                end
            end
            default: begin
                m_settle = 0;
                if (!old_link) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        check("outs", dut_vec(), model_vec());
    endtask

    task automatic wait_rise(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (link_rise) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic send_cmd(input int unsigned f);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_freq  = f;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_link",  64'(link),             64'(0));
        check("rst_rise",  64'(link_rise),        64'(0));
        check("rst_cur",   64'(cur_freq),         64'(F0));
        check("rst_ready", 64'(cmd_if.cmd_ready), 64'(1));
        check("rst_err",   64'(cmd_if.cmd_err),   64'(0));
        check("rst_alive", 64'(swipt_alive),      64'(0));
        check("rst_rdy",   64'(freq_rdy),         64'(0));
    endtask

    initial begin
        longint      c0;
        longint      first_rise;
        longint      chk_at;
        bit          chk_exp;
        bit          all_alive;
        bit          ok;
        int          n_rise;
        int          n_rise_unrdy;
        int          n_stop;
        int          hold;
        int          cmd_at;
        int unsigned f;

        nrst = 1'b1;
        en   = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_freq  = '0;
        repeat (3) tick();
        check_reset_values();
        nrst = 1'b0;
        tick();

        // Default carrier from reset: first rise, rise count and settle timing.
        en         = 1'b1;
        c0         = cyc + 1;
        first_rise = -1;
        chk_at     = -1;
        chk_exp    = 0;
        all_alive  = 1;
        n_rise     = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            all_alive &= swipt_alive;
            if (cyc == chk_at) check("rdy_settle", 64'(freq_rdy), 64'(chk_exp));
            if (link_rise) begin
                n_rise++;
                if (n_rise == 1) first_rise = cyc - c0;
                if (n_rise == 7) begin chk_at = cyc + 1; chk_exp = 0; end
                if (n_rise == 8) begin chk_at = cyc + 1; chk_exp = 1; end
            end
        end
        check("first_rise", 64'(first_rise), 64'(1112));
        check("rises_45k",  64'(n_rise),     64'(9));
        check("alive_run",  64'(all_alive),  64'(1));

        // Out-of-range commands complete but change nothing.
        send_cmd(0);
        check("err_zero",     64'(cmd_if.cmd_err), 64'(1));
        check("err_zero_cur", 64'(cur_freq),       64'(F0));
        check("err_zero_rdy", 64'(freq_rdy),       64'(1));
        tick();
        check("err_zero_end", 64'(cmd_if.cmd_err), 64'(0));
        send_cmd(250000);
        check("err_big",      64'(cmd_if.cmd_err), 64'(1));
        check("err_big_cur",  64'(cur_freq),       64'(F0));
        tick();
        check("err_big_end",  64'(cmd_if.cmd_err), 64'(0));
        check("err_big_rdy",  64'(freq_rdy),       64'(1));

`ifdef SWIPT_TX_SLEW_EN
        send_cmd(48000);
        check("slew_ready_drop", 64'(cmd_if.cmd_ready), 64'(0));
        for (int k = 1; k <= 3; k++) begin
            wait_rise(3000, ok);
            check("slew_rise_seen", 64'(ok), 64'(1));
            tick();
            check("slew_step", 64'(cur_freq), 64'(F0 + 1000 * k));
        end
        check("slew_ready_back", 64'(cmd_if.cmd_ready), 64'(1));
`else
        send_cmd(50000);
        check("jump_ready_drop", 64'(cmd_if.cmd_ready), 64'(0));
        wait_rise(3000, ok);
        check("jump_rise_seen", 64'(ok), 64'(1));
        tick();
        check("jump_cur", 64'(cur_freq), 64'(50000));
        n_rise       = 0;
        n_rise_unrdy = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (link_rise) begin
                n_rise++;
                if (!freq_rdy) n_rise_unrdy++;
            end
        end
        check("rises_50k",   64'(n_rise),       64'(10));
        check("unrdy_rises", 64'(n_rise_unrdy), 64'(8));
`endif

        // Dropping en while link is high lets the high half finish.
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            ok = link;
        end
        check("link_high_seen", 64'(ok), 64'(1));
        en     = 1'b0;
        n_stop = 0;
        for (int i = 0; i < 3000 && swipt_alive; i++) begin
            tick();
            n_stop++;
        end
        check("stop_link",    64'(link),             64'(0));
        check("stop_alive",   64'(swipt_alive),      64'(0));
        check("stop_bounded", 64'(n_stop <= 1200),   64'(1));

        // Reset while slewing.
        en = 1'b1;
        repeat (5) tick();
        send_cmd(60000);
        check("slew_entered", 64'(cmd_if.cmd_ready), 64'(0));
        repeat (3) tick();
        nrst = 1'b1;
        tick();
        check_reset_values();
        nrst = 1'b0;

        for (int it = 0; it < 25; it++) begin
            en     = ($urandom_range(0, 9) < 7);
            hold   = int'($urandom_range(100, 1500));
            cmd_at = int'($urandom_range(0, hold - 1));
            for (int t = 0; t < hold; t++) begin
                if (t == cmd_at) begin
                    case ($urandom_range(0, 7))
                        0:       f = 0;
                        1:       f = F_MAX;
                        2:       f = F_MAX + 1;
                        3:       f = $urandom;
                        4:       f = m_cur;
                        default: f = $urandom_range(20000, F_MAX);
                    endcase
                    send_cmd(f);
                end else begin
                    tick();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
